// File: rtl/phoenix_load_ctrl.sv
// ROM download controller: forwards the HPS ioctl byte stream to the game core one cycle late,
// validates the image (range, ordering, length) and sequences the core reset around loads.
module phoenix_load_ctrl #(
  parameter int ROM_SIZE    = 25088,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        rst_req,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        loaded,
  output logic        load_err,
  output logic [7:0]  checksum,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [24:0] ROM_LIMIT   = 25'(ROM_SIZE);
  localparam logic [16:0] ROM_COUNT   = 17'(ROM_SIZE);
  localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_hold_cnt;
  logic [16:0] r_byte_cnt;
  logic [24:0] r_last_addr;
  logic [15:0] r_dn_addr;
  logic [7:0]  r_dn_data;
  logic        r_dn_wr;
  logic        r_core_reset;
  logic        r_loaded;
  logic        r_load_err;
  logic [7:0]  r_checksum;

  logic        w_in_range;
  logic        w_accept;
  logic        w_seq_err;
  logic        w_range_err;
  logic        w_err_next;
  logic        w_enter_load;
  logic        w_complete;
  logic [24:0] w_expect_addr;
  logic [16:0] w_cnt_next;
  logic [7:0]  w_sum_next;

  // Handshake: ioctl_wr is a valid-only strobe with no ready; every strobe seen in LOAD is
  // consumed in the cycle it appears, so dn_wr pulses mirror accepted strobes one cycle later.
  always_comb begin
    w_in_range    = (ioctl_addr < ROM_LIMIT);
    w_accept      = ioctl_wr && w_in_range;
    w_range_err   = ioctl_wr && !w_in_range;
    w_expect_addr = (r_byte_cnt == 17'd0) ? 25'd0 : (r_last_addr + 25'd1);
    w_seq_err     = w_accept && (ioctl_addr != w_expect_addr);
    w_err_next    = r_load_err || w_seq_err || w_range_err;
    w_cnt_next    = r_byte_cnt;
    if (w_accept && (r_byte_cnt != 17'h1FFFF)) begin
      w_cnt_next = r_byte_cnt + 17'd1;
    end
    w_sum_next    = w_accept ? (r_checksum + ioctl_dout) : r_checksum;
    // The completion check folds in a strobe that lands on the download falling edge.
    w_complete    = !w_err_next && (w_cnt_next == ROM_COUNT);
    w_enter_load  = ioctl_download && (r_state != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_last_addr  <= '0;
      r_dn_addr    <= '0;
      r_dn_data    <= '0;
      r_dn_wr      <= 1'b0;
      r_core_reset <= 1'b1;
      r_loaded     <= 1'b0;
      r_load_err   <= 1'b0;
      r_checksum   <= '0;
    end else begin
      r_dn_wr <= 1'b0;
      if (w_enter_load) begin
        r_state      <= ST_LOAD;
        r_core_reset <= 1'b1;
        r_byte_cnt   <= '0;
        r_last_addr  <= '0;
        r_checksum   <= '0;
        r_load_err   <= 1'b0;
        r_loaded     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state      <= ST_HOLD;
            r_hold_cnt   <= HOLD_RELOAD;
            r_core_reset <= 1'b1;
          end
          ST_LOAD: begin
            if (w_accept) begin
              r_dn_addr   <= ioctl_addr[15:0];
              r_dn_data   <= ioctl_dout;
              r_dn_wr     <= 1'b1;
              r_last_addr <= ioctl_addr;
            end
            r_byte_cnt <= w_cnt_next;
            r_checksum <= w_sum_next;
            if (ioctl_download) begin
              r_load_err <= w_err_next;
            end else begin
              r_state    <= ST_HOLD;
              r_hold_cnt <= HOLD_RELOAD;
              r_loaded   <= w_complete;
              r_load_err <= !w_complete;
            end
          end
          ST_HOLD: begin
            if (rst_req) begin
              r_hold_cnt <= HOLD_RELOAD;
            end else if (r_hold_cnt == 16'd0) begin
              r_state      <= ST_RUN;
              r_core_reset <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt - 16'd1;
            end
          end
          ST_RUN: begin
            if (rst_req) begin
              r_state      <= ST_HOLD;
              r_hold_cnt   <= HOLD_RELOAD;
              r_core_reset <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_wr      = r_dn_wr;
  assign core_reset = r_core_reset;
  assign loaded     = r_loaded;
  assign load_err   = r_load_err;
  assign checksum   = r_checksum;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_phoenix_load_ctrl.sv
// Bench for phoenix_load_ctrl with ROM_SIZE=16, HOLD_CYCLES=4: a table of download scenarios
// plus hand-written reset-request and mid-load reset sequences; core writes go through exp_q.
module tb_phoenix_load_ctrl;

  localparam int ROM_SIZE    = 16;
  localparam int HOLD_CYCLES = 4;

  logic        clk;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        rst_req;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        loaded;
  logic        load_err;
  logic [7:0]  checksum;
  logic [1:0]  dbg_state;

  phoenix_load_ctrl #(
    .ROM_SIZE   (ROM_SIZE),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .rst_req       (rst_req),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .core_reset    (core_reset),
    .loaded        (loaded),
    .load_err      (load_err),
    .checksum      (checksum),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by 300000 ns, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  // {expected cycle[15:0], addr[15:0], data[7:0]}
  logic [39:0] exp_q[$];
  logic [39:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (dn_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dn_wr_unexpected: got write addr 0x%0h data 0x%0h at cycle %0d, want no write",
                 dn_addr, dn_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("dn_wr_cycle", 32'(cyc[15:0]), 32'(mon_e[39:24]));
        check("dn_addr_data", {8'h00, dn_addr, dn_data}, {8'h00, mon_e[23:0]});
      end
    end else if (exp_q.size() > 0 && exp_q[0][39:24] <= cyc[15:0]) begin
      mon_e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL dn_wr_missing: got no write at cycle %0d, want addr 0x%0h data 0x%0h",
               cyc, mon_e[23:8], mon_e[7:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_dl();
    @(negedge clk);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b1;
  endtask

  task automatic stop_dl();
    @(negedge clk);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit accept,
                           input bit drop);
    @(negedge clk);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (drop) ioctl_download = 1'b0;
    if (accept) exp_q.push_back({16'(cyc + 1), a[15:0], d});
  endtask

  // Counts sampled cycles with core_reset high, starting with the current sample.
  task automatic measure_hold(output int n);
    n = (core_reset === 1'b1) ? 1 : 0;
    for (int i = 0; i < 100 && core_reset === 1'b1; i++) begin
      @(posedge clk);
      #1;
      if (core_reset === 1'b1) n++;
    end
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int         n;          // bytes streamed, data = addr + 1
    int         swap_at;    // swap order of bytes swap_at/swap_at+1, -1 = in order
    bit         bad_wr;     // extra strobe at addr 16, data 0xFF
    bit         overlap;    // last strobe coincides with download falling edge
    bit         exp_loaded;
    bit         exp_err;
    logic [7:0] exp_sum;
  } vec_t;

  vec_t vecs[9];

  task automatic run_load(input vec_t v, input int idx);
    logic [24:0] a;
    bit          dropped;
    int          n;
    string       tag;
    dropped = 1'b0;
    tag = $sformatf("vec%0d", idx);
    start_dl();
    for (int i = 0; i < v.n; i++) begin
      a = 25'(i);
      if (v.swap_at >= 0 && i == v.swap_at) a = 25'(i + 1);
      if (v.swap_at >= 0 && i == v.swap_at + 1) a = 25'(i - 1);
      dropped = v.overlap && !v.bad_wr && (i == v.n - 1);
      send_byte(a, 8'(a + 25'd1), 1'b1, dropped);
    end
    if (v.bad_wr) begin
      dropped = v.overlap;
      send_byte(25'd16, 8'hFF, 1'b0, dropped);
    end
    if (!dropped) stop_dl();
    @(posedge clk);
    #1;
    ioctl_wr = 1'b0;
    check({tag, "_state_hold"}, 32'(dbg_state), 32'd2);
    check({tag, "_loaded"}, 32'(loaded), 32'(v.exp_loaded));
    check({tag, "_load_err"}, 32'(load_err), 32'(v.exp_err));
    check({tag, "_checksum"}, 32'(checksum), 32'(v.exp_sum));
    measure_hold(n);
    check({tag, "_hold_len"}, 32'(n), 32'(HOLD_CYCLES));
    check({tag, "_run_state"}, 32'(dbg_state), 32'd3);
    check({tag, "_run_flags"}, {22'd0, loaded, load_err, checksum}, {22'd0, v.exp_loaded, v.exp_err, v.exp_sum});
  endtask

  // ---------------- main sequence ----------------
  int n;
  int m;

  initial begin
    vecs[0] = '{15, -1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h78};  // short image
    vecs[1] = '{16, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h88};  // full image
    vecs[2] = '{16, -1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h88};  // overrange strobe
    vecs[3] = '{16, -1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h88};  // last byte on falling edge
    vecs[4] = '{16,  4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h88};  // out-of-order addresses
    vecs[5] = '{16,  0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h88};  // first strobe not address 0
    vecs[6] = '{0,  -1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};  // empty download
    vecs[7] = '{16, -1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h88};  // overrange on falling edge
    vecs[8] = '{16, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h88};  // full image after errors

    reset          = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    rst_req        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_dn_wr", 32'(dn_wr), 32'd0);
    check("rst_dn_addr_data", {8'h00, dn_addr, dn_data}, 32'd0);
    check("rst_flags", {22'd0, loaded, load_err, checksum}, 32'd0);
    check("rst_state_idle", 32'(dbg_state), 32'd0);

    // Release: IDLE -> HOLD -> RUN with no download pending.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    measure_hold(n);
    check("boot_run_state", 32'(dbg_state), 32'd3);
    check("boot_core_reset", 32'(core_reset), 32'd0);

    for (int i = 0; i < 9; i++) run_load(vecs[i], i);

    // Strobe while in RUN must be ignored.
    send_byte(25'd0, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(posedge clk);
    #1;
    check("run_wr_ignored_flags", {22'd0, loaded, load_err, checksum}, {22'd0, 1'b1, 1'b0, 8'h88});
    check("run_wr_ignored_state", 32'(dbg_state), 32'd3);

    // One-cycle reset request from RUN.
    @(negedge clk);
    rst_req = 1'b1;
    @(posedge clk);
    #1;
    rst_req = 1'b0;
    measure_hold(n);
    check("rst_req_pulse_len", 32'(n), 32'(HOLD_CYCLES));

    // Reset request held for 10 cycles.
    @(negedge clk);
    rst_req = 1'b1;
    @(posedge clk);
    #1;
    n = (core_reset === 1'b1) ? 1 : 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (core_reset === 1'b1) n++;
    end
    @(posedge clk);
    #1;
    rst_req = 1'b0;
    measure_hold(m);
    check("rst_req_hold10_len", 32'(n + m), 32'(10 + HOLD_CYCLES - 1));
    check("rst_req_flags_kept", {22'd0, loaded, load_err, checksum}, {22'd0, 1'b1, 1'b0, 8'h88});

    // Reset in the middle of a download, download kept high.
    start_dl();
    for (int i = 0; i < 5; i++) send_byte(25'(i), 8'(i + 1), 1'b1, 1'b0);
    @(negedge clk);
    ioctl_wr = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_flags", {22'd0, loaded, load_err, checksum}, 32'd0);
    check("midrst_dn", {7'd0, dn_wr, dn_addr, dn_data}, 32'd0);
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    check("midrst_state_idle", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_reenter_load", 32'(dbg_state), 32'd1);
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(i + 1), 1'b1, 1'b0);
    stop_dl();
    @(posedge clk);
    #1;
    check("midrst_reload_flags", {22'd0, loaded, load_err, checksum}, {22'd0, 1'b1, 1'b0, 8'h88});
    measure_hold(n);
    check("midrst_hold_len", 32'(n), 32'(HOLD_CYCLES));

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
